// File: rtl/joybus_tx_sequencer.sv
// Controller-side joybus response serialiser: turnaround gap, four-quarter
// bit symbols MSB first, controller stop bit, then line release and done.
module joybus_tx_sequencer #(
    parameter int TICKS_PER_QUARTER = 16,
    parameter int GAP_TICKS         = 32,
    parameter int MAX_BYTES         = 4
) (
    input  logic                   sample_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             byte_count,
    input  logic [8*MAX_BYTES-1:0] tx_data,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   data_tx,
    output logic                   data_oe
);
    localparam int DW   = 8 * MAX_BYTES;
    localparam int BW   = $clog2(DW);
    localparam int NW   = $clog2(MAX_BYTES + 1);
    localparam int TMAX = (GAP_TICKS > TICKS_PER_QUARTER) ? GAP_TICKS : TICKS_PER_QUARTER;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, GAP, BIT, STOP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [NW-1:0]   n_q, n_d;
    logic            done_q, done_d;
    logic            oe_q, oe_d;
    logic            tx_q, tx_d;
    logic            tick_end, gap_end, last_bit;

    assign tick_end = (tick_q == TW'(TICKS_PER_QUARTER - 1));
    assign gap_end  = (tick_q == TW'(GAP_TICKS - 1));
    assign last_bit = (int'(bit_q) == 8 * int'(n_q) - 1);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        n_d     = n_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = GAP;
                    shift_d = tx_data;
                    n_d     = (int'(byte_count) > MAX_BYTES) ? NW'(MAX_BYTES) : NW'(byte_count);
                end
            end
            GAP: begin
                if (abort)        state_d = IDLE;
                else if (gap_end) state_d = (n_q == '0) ? STOP : BIT;
                else              tick_d  = tick_q + TW'(1);
            end
            BIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick_end) begin
                    tick_d = '0;
                    qtr_d  = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        shift_d = shift_q << 1;
                        if (last_bit) state_d = STOP;
                        else          bit_d   = bit_q + BW'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            STOP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick_end) begin
                    tick_d = '0;
                    qtr_d  = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Every state change restarts the tick/quarter/bit counters.
        if (state_d != state_q) begin
            tick_d = '0;
            qtr_d  = '0;
            bit_d  = '0;
        end

        // Line levels are decoded from the next state so they register on the same edge.
        oe_d = 1'b0;
        tx_d = 1'b1;
        case (state_d)
            BIT: begin
                oe_d = 1'b1;
                case (qtr_d)
                    2'd0:    tx_d = 1'b0;
                    2'd3:    tx_d = 1'b1;
                    default: tx_d = shift_d[DW-1];
                endcase
            end
            STOP: begin
                if (qtr_d != 2'd3) begin
                    oe_d = 1'b1;
                    tx_d = (qtr_d == 2'd2);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
            oe_q    <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            n_q     <= n_d;
            done_q  <= done_d;
            oe_q    <= oe_d;
            tx_q    <= tx_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign data_oe = oe_q;
    assign data_tx = tx_q;
endmodule

// File: tb/tb_joybus_tx_sequencer.sv
// Scoreboard bench: each accepted start queues the expected per-cycle
// {busy, done, data_oe, data_tx} waveform; a negedge monitor pops and compares.
module tb_joybus_tx_sequencer;
    localparam int TPQ = 2;
    localparam int GAP = 4;
    localparam int MB  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  bc = 3'd0;
    logic [31:0] txd = 32'h0;
    logic        busy, done, data_tx, data_oe;

    int          total = 0;
    int          bad = 0;
    logic [3:0]  exp_q[$];
    int          len_q[$];
    bit          mon_en = 1'b0;
    int          busy_cnt = 0;
    logic [3:0]  obs;

    joybus_tx_sequencer #(
        .TICKS_PER_QUARTER(TPQ),
        .GAP_TICKS(GAP),
        .MAX_BYTES(MB)
    ) dut (
        .sample_clk(clk),
        .reset(reset),
        .start(start),
        .byte_count(bc),
        .tx_data(txd),
        .abort(abort),
        .busy(busy),
        .done(done),
        .data_tx(data_tx),
        .data_oe(data_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void push_frame(input logic [2:0] c, input logic [31:0] d);
        int          n = (int'(c) > MB) ? MB : int'(c);
        logic [31:0] sh = d;
        logic        b;
        logic        lvl;
        for (int i = 0; i < GAP; i++) exp_q.push_back(4'b1001);
        for (int i = 0; i < 8 * n; i++) begin
            b  = sh[31];
            sh = sh << 1;
            for (int q = 0; q < 4; q++) begin
                lvl = (q == 0) ? 1'b0 : (q == 3) ? 1'b1 : b;
                for (int t = 0; t < TPQ; t++) exp_q.push_back({3'b101, lvl});
            end
        end
        for (int q = 0; q < 4; q++)
            for (int t = 0; t < TPQ; t++)
                exp_q.push_back((q == 3) ? 4'b1001 : {3'b101, (q == 2)});
        exp_q.push_back(4'b0101);
        len_q.push_back(GAP + (8 * n + 1) * 4 * TPQ);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            obs = {busy, done, data_oe, data_tx};
            if (exp_q.size() > 0) chk("wave", 32'(obs), 32'(exp_q.pop_front()));
            else                  chk("idle", 32'(obs), 32'h1);
            if (busy) begin
                busy_cnt++;
            end else begin
                if (done) begin
                    if (len_q.size() > 0) chk("frame_len", busy_cnt, len_q.pop_front());
                    else                  chk("spurious_done", 32'(done), 32'h0);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] c, input logic [31:0] d);
        start = 1'b1;
        bc    = c;
        txd   = d;
        @(posedge clk);
        push_frame(c, d);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_q.size() > 0 && k < 3000) begin
            tick();
            k++;
        end
        chk("timeout", 32'(exp_q.size()), 32'h0);
        tick();
    endtask

    // Keep only the current cycle's expectation; the frame is being cut short.
    task automatic cut();
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        if (len_q.size() > 0) void'(len_q.pop_back());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        launch(3'd1, 32'h8000_0000);
        wait_done();
        launch(3'd4, 32'h0500_0200);
        wait_done();
        launch(3'd0, 32'hFFFF_FFFF);
        wait_done();
        launch(3'd7, 32'h0500_0200);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            launch(3'($urandom_range(0, 7)), $urandom);
            wait_done();
        end

        launch(3'd4, 32'hA5C3_0F96);
        repeat (GAP + 5 * 4 * TPQ + 3) tick();
        abort = 1'b1;
        cut();
        tick();
        abort = 1'b0;
        tick();
        launch(3'd2, 32'h1234_5678);
        wait_done();

        launch(3'd3, 32'hC0FF_EE00);
        for (int i = 0; i < 10; i++) begin
            repeat (7) tick();
            start = 1'b1;
            txd   = $urandom;
            bc    = 3'($urandom_range(0, 7));
            tick();
            start = 1'b0;
        end
        wait_done();

        launch(3'd1, 32'h3C00_0000);
        repeat (GAP + 8 * 4 * TPQ + 2) tick();
        reset = 1'b1;
        cut();
        tick();
        reset = 1'b0;
        repeat (3) tick();

        abort = 1'b1;
        tick();
        start = 1'b1;
        bc    = 3'd4;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (5) tick();

        start = 1'b1;
        bc    = 3'd1;
        txd   = 32'h8000_0000;
        @(posedge clk);
        push_frame(3'd1, 32'h8000_0000);
        #1;
        k = 0;
        while (exp_q.size() != 1 && k < 3000) begin
            tick();
            k++;
        end
        chk("held_start_reach_done", 32'(exp_q.size()), 32'h1);
        txd = 32'h4000_0000;
        @(posedge clk);
        push_frame(3'd1, 32'h4000_0000);
        #1;
        start = 1'b0;
        wait_done();

        repeat (3) tick();
        chk("drain_len", 32'(len_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
